// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding and default widths for the row-stationary PE
package pe_pkg;

  localparam int DEF_BITWIDTH         = 16;
  localparam int DEF_RF_ADDR_WIDTH    = 3;
  localparam int DEF_KERNEL_SIZE      = 3;
  localparam int DEF_WHEN_TO_ACC_PSUM = 6;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    WAIT    = 2'd2,
    DONE    = 2'd3
  } pe_state_t;

endpackage

// File: rtl/pe_rf.sv
// rtl/pe_rf.sv - register file with pointer or direct-address writes, full flag and async read
module pe_rf
  import pe_pkg::*;
#(
  parameter int BITWIDTH      = DEF_BITWIDTH,
  parameter int RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     i_wr_en,
  input  logic                     i_wr_direct,
  input  logic [RF_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [BITWIDTH-1:0]      i_wr_data,
  input  logic [RF_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [BITWIDTH-1:0]      o_rd_data,
  output logic [RF_ADDR_WIDTH:0]   o_fill,
  output logic                     o_full
);

  localparam int DEPTH = 2 ** RF_ADDR_WIDTH;

  logic [BITWIDTH-1:0]    memory [DEPTH];
  logic [RF_ADDR_WIDTH:0] r_wptr;

  assign o_fill    = r_wptr;
  // The pointer only ever reaches DEPTH, so its top bit alone marks full.
  assign o_full    = r_wptr[RF_ADDR_WIDTH];
  assign o_rd_data = memory[i_rd_addr];

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      for (int j = 0; j < DEPTH; j++) memory[j] <= '0;
      r_wptr <= '0;
    end else if (i_wr_en) begin
      if (i_wr_direct) begin
        memory[i_wr_addr] <= i_wr_data;
      end else if (!o_full) begin
        memory[r_wptr[RF_ADDR_WIDTH-1:0]] <= i_wr_data;
        r_wptr <= r_wptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_stationary_pe.sv
// rtl/row_stationary_pe.sv - row-stationary PE: load filter/ifmap rows, signed MAC, chained psum add
module row_stationary_pe
  import pe_pkg::*;
#(
  parameter int BITWIDTH         = DEF_BITWIDTH,
  parameter int RF_ADDR_WIDTH    = DEF_RF_ADDR_WIDTH,
  parameter int KERNEL_SIZE      = DEF_KERNEL_SIZE,
  parameter int WHEN_TO_ACC_PSUM = DEF_WHEN_TO_ACC_PSUM
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       ifmap_enable,
  input  logic                       filter_enable,
  input  logic signed [BITWIDTH-1:0] ifmap,
  input  logic signed [BITWIDTH-1:0] filter,
  input  logic signed [BITWIDTH-1:0] input_psum,
  output logic                       ready,
  output logic signed [BITWIDTH-1:0] output_psum
);

  localparam int CW = $clog2(WHEN_TO_ACC_PSUM + 2);
  localparam int AW = RF_ADDR_WIDTH;
  localparam logic [AW:0]   KFILL  = (AW + 1)'(KERNEL_SIZE);
  localparam logic [CW-1:0] C_LAST = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] C_ACC  = CW'(WHEN_TO_ACC_PSUM);

  pe_state_t               pe_state, w_next_state;
  logic [CW-1:0]           count, w_next_count;
  logic [AW-1:0]           filter_select, ifmap_select, psum_select;
  logic                    acc_reset, acc_input_psum;
  logic [BITWIDTH-1:0]     filter_from_fifo, ifmap_from_fifo, psum_from_fifo;
  logic [AW:0]             w_filter_fill, w_ifmap_fill, w_psum_fill;
  logic                    w_filter_full, w_ifmap_full, w_psum_full;
  logic                    w_filter_we, w_ifmap_we, w_psum_we;
  logic signed [BITWIDTH-1:0]   r_psum, w_psum_next, w_psum_acc;
  logic signed [2*BITWIDTH-1:0] w_product_full;
  logic signed [BITWIDTH-1:0]   mac_multiplier, mac_accumulator;

  assign filter_select  = AW'(count);
  assign ifmap_select   = AW'(count);
  assign psum_select    = '0;
  assign acc_reset      = (pe_state == COMPUTE) && (count == '0);
  assign acc_input_psum = (pe_state == WAIT) && (count == C_ACC);
  assign w_filter_we    = (pe_state == LOAD) && filter_enable;
  assign w_ifmap_we     = (pe_state == LOAD) && ifmap_enable;

  pe_rf #(.BITWIDTH(BITWIDTH), .RF_ADDR_WIDTH(AW)) filter_fifo (
    .clk(clk), .rstb(rstb), .i_wr_en(w_filter_we), .i_wr_direct(1'b0), .i_wr_addr('0),
    .i_wr_data(filter), .i_rd_addr(filter_select), .o_rd_data(filter_from_fifo),
    .o_fill(w_filter_fill), .o_full(w_filter_full)
  );

  pe_rf #(.BITWIDTH(BITWIDTH), .RF_ADDR_WIDTH(AW)) ifmap_fifo (
    .clk(clk), .rstb(rstb), .i_wr_en(w_ifmap_we), .i_wr_direct(1'b0), .i_wr_addr('0),
    .i_wr_data(ifmap), .i_rd_addr(ifmap_select), .o_rd_data(ifmap_from_fifo),
    .o_fill(w_ifmap_fill), .o_full(w_ifmap_full)
  );

  // The psum RF is always addressed directly at psum_select; its pointer stays idle.
  pe_rf #(.BITWIDTH(BITWIDTH), .RF_ADDR_WIDTH(AW)) psum_fifo (
    .clk(clk), .rstb(rstb), .i_wr_en(w_psum_we), .i_wr_direct(1'b1), .i_wr_addr(psum_select),
    .i_wr_data(w_psum_next), .i_rd_addr(psum_select), .o_rd_data(psum_from_fifo),
    .o_fill(w_psum_fill), .o_full(w_psum_full)
  );

  // Product and sum wrap at BITWIDTH; no saturation anywhere in the datapath.
  assign w_product_full  = $signed(filter_from_fifo) * $signed(ifmap_from_fifo);
  assign mac_multiplier  = w_product_full[BITWIDTH-1:0];
  assign mac_accumulator = (acc_reset ? '0 : r_psum) + mac_multiplier;
  assign w_psum_acc      = r_psum + input_psum;

  assign ready       = (pe_state == LOAD);
  assign output_psum = acc_input_psum ? w_psum_acc : r_psum;

  always_comb begin
    w_next_state = pe_state;
    w_next_count = count;
    w_psum_next  = r_psum;
    w_psum_we    = 1'b0;
    case (pe_state)
      LOAD: begin
        if (w_filter_fill >= KFILL && w_ifmap_fill >= KFILL) begin
          w_next_state = COMPUTE;
          w_next_count = '0;
        end
      end
      COMPUTE: begin
        w_psum_next  = mac_accumulator;
        w_next_count = count + 1'b1;
        if (count == C_LAST) begin
          w_psum_we    = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_next_count = count + 1'b1;
        if (acc_input_psum) begin
          w_psum_next  = w_psum_acc;
          w_psum_we    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = DONE;
      end
      default: begin
        w_next_state = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      pe_state <= LOAD;
      count    <= '0;
      r_psum   <= '0;
    end else begin
      pe_state <= w_next_state;
      count    <= w_next_count;
      r_psum   <= w_psum_next;
    end
  end

endmodule

// File: tb/tb_row_stationary_pe.sv
// tb/tb_row_stationary_pe.sv - self-checking bench for row_stationary_pe with a dot-product reference model
module tb_row_stationary_pe;
  import pe_pkg::*;

  localparam int K    = 3;
  localparam int WHEN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstb;
  logic               fen, ien;
  logic signed [15:0] f_in, i_in, ip;
  logic               ready;
  logic signed [15:0] opsum;

  row_stationary_pe dut (
    .clk(clk), .rstb(rstb), .ifmap_enable(ien), .filter_enable(fen),
    .ifmap(i_in), .filter(f_in), .input_psum(ip), .ready(ready), .output_psum(opsum)
  );

  logic               c_fen, c_ien;
  logic signed [15:0] cf [3];
  logic signed [15:0] ci [3];
  logic signed [15:0] c_out [3];
  logic               c_rdy [3];

  row_stationary_pe #(.WHEN_TO_ACC_PSUM(5)) u_bot (
    .clk(clk), .rstb(rstb), .ifmap_enable(c_ien), .filter_enable(c_fen),
    .ifmap(ci[0]), .filter(cf[0]), .input_psum(16'sd0), .ready(c_rdy[0]), .output_psum(c_out[0])
  );
  row_stationary_pe #(.WHEN_TO_ACC_PSUM(6)) u_mid (
    .clk(clk), .rstb(rstb), .ifmap_enable(c_ien), .filter_enable(c_fen),
    .ifmap(ci[1]), .filter(cf[1]), .input_psum(c_out[0]), .ready(c_rdy[1]), .output_psum(c_out[1])
  );
  row_stationary_pe #(.WHEN_TO_ACC_PSUM(6)) u_top (
    .clk(clk), .rstb(rstb), .ifmap_enable(c_ien), .filter_enable(c_fen),
    .ifmap(ci[2]), .filter(cf[2]), .input_psum(c_out[1]), .ready(c_rdy[2]), .output_psum(c_out[2])
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic signed [15:0] tf [3];
  logic signed [15:0] ti [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap16(input longint v);
    logic signed [15:0] r;
    r = v[15:0];
    return int'(r);
  endfunction

  function automatic int dot_model(input logic signed [15:0] a [3], input logic signed [15:0] b [3]);
    longint acc = 0;
    for (int k = 0; k < K; k++) acc += longint'(a[k]) * longint'(b[k]);
    return wrap16(acc);
  endfunction

  function automatic int nonzero_entries();
    int n = 0;
    for (int j = 0; j < 8; j++) begin
      if (dut.filter_fifo.memory[j] != 0) n++;
      if (dut.ifmap_fifo.memory[j] != 0) n++;
      if (dut.psum_fifo.memory[j] != 0) n++;
    end
    return n;
  endfunction

  task automatic do_reset;
    rstb = 1'b1; fen = 1'b0; ien = 1'b0; ip = '0;
    tick; tick;
    rstb = 1'b0;
  endtask

  task automatic load_row(input bit alt);
    for (int k = 0; k < K; k++) begin
      if (alt) begin
        f_in = tf[k]; fen = 1'b1; ien = 1'b0; tick;
        fen = 1'b0; i_in = ti[k]; ien = 1'b1; tick;
        ien = 1'b0;
      end else begin
        f_in = tf[k]; i_in = ti[k]; fen = 1'b1; ien = 1'b1; tick;
        fen = 1'b0; ien = 1'b0;
      end
    end
  endtask

  // Entered with the PE at compute count 0; checks the dot product, the one-cycle add, then the hold.
  task automatic run_and_check(input string tag, input logic signed [15:0] psum_in);
    int d;
    d = dot_model(tf, ti);
    for (int k = 0; k < K; k++) tick;
    check({tag, "_dot"}, int'(opsum), d);
    ip = psum_in;
    for (int k = K; k < WHEN; k++) tick;
    check({tag, "_acc"}, int'(opsum), wrap16(longint'(d) + longint'(psum_in)));
    tick;
    ip = 16'($urandom);
    check({tag, "_hold"}, int'(opsum), wrap16(longint'(d) + longint'(psum_in)));
    check({tag, "_ready"}, int'(ready), 0);
  endtask

  initial begin
    rstb = 1'b1; fen = 1'b0; ien = 1'b0; f_in = '0; i_in = '0; ip = '0;
    c_fen = 1'b0; c_ien = 1'b0;
    for (int p = 0; p < 3; p++) begin cf[p] = '0; ci[p] = '0; end
    tick; tick; tick;
    check("rst_ready", int'(ready), 1);
    check("rst_psum", int'(opsum), 0);
    check("rst_state", int'(dut.pe_state), int'(LOAD));
    check("rst_rf", nonzero_entries(), 0);
    rstb = 1'b0;

    tf = '{16'sd1, 16'sd2, 16'sd3};
    ti = '{16'sd5, 16'sd6, 16'sd7};
    load_row(1'b1);
    check("basic_ready_after_load", int'(ready), 1);
    tick;
    check("basic_compute_start", int'(ready), 0);
    run_and_check("basic", 16'sd100);

    do_reset;
    cf = '{16'sd7, 16'sd4, 16'sd1};
    ci = '{16'sd11, 16'sd8, 16'sd5};
    for (int k = 0; k < K; k++) begin
      cf[0] = 16'(7 + k);  ci[0] = 16'(11 + k);
      cf[1] = 16'(4 + k);  ci[1] = 16'(8 + k);
      cf[2] = 16'(1 + k);  ci[2] = 16'(5 + k);
      c_fen = 1'b1; c_ien = 1'b1; tick;
    end
    c_fen = 1'b0; c_ien = 1'b0;
    tick;
    for (int k = 0; k < WHEN; k++) tick;
    check("chain_bottom", int'(c_out[0]), 290);
    check("chain_mid", int'(c_out[1]), 427);
    check("chain_top", int'(c_out[2]), 465);
    tick;
    check("chain_top_hold", int'(c_out[2]), 465);
    check("chain_top_ready", int'(c_rdy[2]), 0);

    do_reset;
    tf = '{16'sd256, 16'sd0, 16'sd0};
    ti = '{16'sd256, 16'sd0, 16'sd0};
    load_row(1'b0);
    tick;
    run_and_check("wrap", -16'sd1);

    do_reset;
    for (int k = 0; k < 9; k++) begin
      f_in = 16'(k + 1); fen = 1'b1; tick;
    end
    fen = 1'b0;
    check("full_first", int'($signed(dut.filter_fifo.memory[0])), 1);
    check("full_last", int'($signed(dut.filter_fifo.memory[7])), 8);
    check("full_ready", int'(ready), 1);
    tf = '{16'sd1, 16'sd2, 16'sd3};
    for (int k = 0; k < K; k++) begin
      ti[k] = 16'($urandom);
      i_in = ti[k]; ien = 1'b1; tick;
    end
    ien = 1'b0;
    tick;
    fen = 1'b1; ien = 1'b1; f_in = 16'sh7fff; i_in = 16'sh7fff;
    run_and_check("ignore_en", 16'($urandom));
    check("ignore_en_frf", int'($signed(dut.filter_fifo.memory[0])), 1);
    check("ignore_en_irf", int'($signed(dut.ifmap_fifo.memory[0])), int'(ti[0]));
    fen = 1'b0; ien = 1'b0;

    do_reset;
    for (int k = 0; k < K; k++) begin tf[k] = 16'($urandom); ti[k] = 16'($urandom); end
    load_row(1'b0);
    tick; tick; tick;
    rstb = 1'b1;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_psum", int'(opsum), 0);
    check("abort_state", int'(dut.pe_state), int'(LOAD));
    check("abort_rf", nonzero_entries(), 0);
    tick;
    rstb = 1'b0;
    for (int k = 0; k < K; k++) begin tf[k] = 16'($urandom); ti[k] = 16'($urandom); end
    load_row(1'b1);
    tick;
    run_and_check("reload", 16'($urandom));

    for (int it = 0; it < 12; it++) begin
      do_reset;
      for (int k = 0; k < K; k++) begin
        tf[k] = (it < 4) ? 16'($urandom_range(0, 40)) : 16'($urandom);
        ti[k] = (it < 4) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      end
      load_row(1'($urandom_range(0, 1)));
      tick;
      check("rand_start", int'(ready), 0);
      run_and_check("rand", 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
